avm_uart_tx_arbiter: RTL and testbench

Avalon-MM master that configures and sequences the UART slave's register map on behalf of NUM_REQ byte-stream requesters.
After reset it programs the clock divider and control registers. It then grants requesters round-robin, polls the UART status register until the transmitter is ready, and writes each granted byte to the tx_data register.
It sits between on-chip byte producers (debug, log, CLI) and the UART slave's Avalon port, so a single UART is shared without software involvement.

---
 rtl/avm_uart_pkg.sv | 23 ++
 rtl/avm_uart_tx_arbiter_rr_arbiter.sv | 33 +++
 rtl/avm_uart_tx_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_avm_uart_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avm_uart_pkg.sv
// Shared definitions for the Avalon-MM UART transmit arbiter.
// Holds the UART register map, status bit positions and the sequencer state enum.
package avm_uart_pkg;

  localparam logic [2:0] UART_REG_RX   = 3'd0;
  localparam logic [2:0] UART_REG_TX   = 3'd1;
  localparam logic [2:0] UART_REG_CTRL = 3'd2;
  localparam logic [2:0] UART_REG_STAT = 3'd3;
  localparam logic [2:0] UART_REG_DIV  = 3'd4;

  localparam int STAT_TRDY_BIT = 1;
  localparam int STAT_RRDY_BIT = 0;

  typedef enum logic [2:0] {
    ST_INIT_DIV,
    ST_INIT_CTRL,
    ST_IDLE,
    ST_POLL,
    ST_GAP,
    ST_WRITE
  } arb_state_t;

endpackage

// File: rtl/avm_uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The pointer register lives in the parent so the grant can be committed there.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  // Walk offsets from the far end down so the nearest requester wins last.
  always_comb begin
    int j;
    grant_idx = '0;
    any_req   = 1'b0;
    j         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        grant_idx = IDX_W'(j);
        any_req   = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign grant[gi] = any_req && (grant_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/avm_uart_tx_arbiter.sv
// Avalon-MM master sharing one UART among NUM_REQ byte producers: init, round-robin grant, poll, write.
// Optional UART_ARB_LOCK_EN adds req_last and keeps the grant until a byte marked last is written.
module avm_uart_tx_arbiter
  import avm_uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLK_DIV_INIT = 434,
  parameter int POLL_GAP     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_last,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [2:0]                 avm_m0_address,
  output logic                       avm_m0_read,
  output logic                       avm_m0_write,
  output logic [31:0]                avm_m0_writedata,
  input  logic [31:0]                avm_m0_readdata,
  input  logic                       avm_m0_waitrequest,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  arb_state_t       state_reg, state_next;
  logic             read_reg, read_next;
  logic             write_reg, write_next;
  logic [2:0]       addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [7:0]       byte_reg, byte_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic             first_tx_reg, first_tx_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [7:0]         sel_byte;
  logic               xfer_done;

`ifdef UART_ARB_LOCK_EN
  logic lock_reg, lock_next;
  logic last_reg, last_next;
  // While locked only the holder of the grant may be picked again.
  assign arb_req = lock_reg ? (req_valid & (NUM_REQ'(1) << grant_reg)) : req_valid;
`else
  assign arb_req = req_valid;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (arb_req),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  assign sel_byte  = req_data[{arb_idx, 3'b000} +: 8];
  assign xfer_done = (read_reg | write_reg) & ~avm_m0_waitrequest;

  // Only status bit trdy matters; the rest of readdata is deliberately dropped.
  logic unused_readdata;
  assign unused_readdata = ^{avm_m0_readdata[31:STAT_TRDY_BIT+1],
                             avm_m0_readdata[STAT_TRDY_BIT-1:0]};

  always_comb begin
    state_next    = state_reg;
    read_next     = read_reg;
    write_next    = write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    byte_next     = byte_reg;
    grant_next    = grant_reg;
    ptr_next      = ptr_reg;
    first_tx_next = first_tx_reg;
    gap_cnt_next  = gap_cnt_reg;
`ifdef UART_ARB_LOCK_EN
    lock_next     = lock_reg;
    last_next     = last_reg;
`endif
    unique case (state_reg)
      ST_INIT_DIV: begin
        if (!write_reg) begin
          write_next = 1'b1;
          addr_next  = UART_REG_DIV;
          wdata_next = 32'(CLK_DIV_INIT);
        end else if (xfer_done) begin
          write_next = 1'b0;
          state_next = ST_INIT_CTRL;
        end
      end
      ST_INIT_CTRL: begin
        if (!write_reg) begin
          write_next = 1'b1;
          addr_next  = UART_REG_CTRL;
          wdata_next = 32'd0;
        end else if (xfer_done) begin
          write_next = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (arb_any) begin
          byte_next  = sel_byte;
          grant_next = arb_idx;
          ptr_next   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
`ifdef UART_ARB_LOCK_EN
          last_next  = req_last[arb_idx];
`endif
          // The very first byte skips polling: the transmitter is idle after init.
          if (first_tx_reg) begin
            state_next = ST_WRITE;
            write_next = 1'b1;
            addr_next  = UART_REG_TX;
            wdata_next = {24'b0, sel_byte};
          end else begin
            state_next = ST_POLL;
            read_next  = 1'b1;
            addr_next  = UART_REG_STAT;
          end
        end
      end
      ST_POLL: begin
        if (xfer_done) begin
          read_next = 1'b0;
          if (avm_m0_readdata[STAT_TRDY_BIT]) begin
            state_next = ST_WRITE;
            write_next = 1'b1;
            addr_next  = UART_REG_TX;
            wdata_next = {24'b0, byte_reg};
          end else begin
            state_next   = ST_GAP;
            gap_cnt_next = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_W'(POLL_GAP - 1)) begin
          state_next = ST_POLL;
          read_next  = 1'b1;
          addr_next  = UART_REG_STAT;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      ST_WRITE: begin
        if (xfer_done) begin
          write_next    = 1'b0;
          first_tx_next = 1'b0;
          state_next    = ST_IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_next     = ~last_reg;
`endif
        end
      end
      default: state_next = ST_INIT_DIV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_INIT_DIV;
      read_reg     <= 1'b0;
      write_reg    <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      byte_reg     <= '0;
      grant_reg    <= '0;
      ptr_reg      <= '0;
      first_tx_reg <= 1'b1;
      gap_cnt_reg  <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_reg     <= 1'b0;
      last_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      read_reg     <= read_next;
      write_reg    <= write_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      byte_reg     <= byte_next;
      grant_reg    <= grant_next;
      ptr_reg      <= ptr_next;
      first_tx_reg <= first_tx_next;
      gap_cnt_reg  <= gap_cnt_next;
`ifdef UART_ARB_LOCK_EN
      lock_reg     <= lock_next;
      last_reg     <= last_next;
`endif
    end
  end

  assign req_ready        = (state_reg == ST_IDLE && !reset) ? arb_grant : '0;
  assign busy             = reset | (state_reg != ST_IDLE);
  assign grant_id         = grant_reg;
  assign avm_m0_address   = addr_reg;
  assign avm_m0_read      = read_reg;
  assign avm_m0_write     = write_reg;
  assign avm_m0_writedata = wdata_reg;

endmodule

// File: tb/tb_avm_uart_tx_arbiter.sv
// Scoreboard bench for avm_uart_tx_arbiter: random requesters and slave behaviour,
// expected Avalon writes queued at grant time and checked by an independent monitor.
module tb_avm_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int CLK_DIV_INIT = 434;
  localparam int POLL_GAP     = 4;
  localparam logic [2:0] A_TX = 3'd1, A_CTRL = 3'd2, A_STAT = 3'd3, A_DIV = 3'd4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0][7:0]     cur_byte;
  logic [NUM_REQ-1:0]          req_ready;
  logic [2:0]                  avm_m0_address;
  logic                        avm_m0_read, avm_m0_write;
  logic [31:0]                 avm_m0_writedata, avm_m0_readdata;
  logic                        avm_m0_waitrequest;
  logic                        busy;
  logic [1:0]                  grant_id;

  always #5 clk = ~clk;

  avm_uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .CLK_DIV_INIT(CLK_DIV_INIT), .POLL_GAP(POLL_GAP)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(cur_byte),
    .req_ready(req_ready), .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read),
    .avm_m0_write(avm_m0_write), .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_readdata(avm_m0_readdata), .avm_m0_waitrequest(avm_m0_waitrequest),
    .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    int          gid;
    int          exp_reads;
    int          exp_lat;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  src_q[NUM_REQ][$];
  bit          pop_req[NUM_REQ];

  int checks = 0, passes = 0;
  int cyc = 0;
  bit in_reset = 1'b1;
  int wait_mode = 0;     // 0 none, 1 random, 2 stall tx writes 5 cycles, 3 stall reads
  int trdy_zeros = 0;
  bit trdy_rand = 1'b0;
  int exp_polls = 1;
  bit clean = 1'b1;
  int valid_pct = 100;

  int model_ptr = 0;
  bit model_first_tx = 1'b1;
  int reads_cnt = 0;
  bit gap_on = 1'b0;
  int gap_cnt = 0;
  bit exp_wr_next = 1'b0;
  bit seen_idle = 1'b0;
  bit ctrl_seen = 1'b0;
  int ctrl_cyc = 0;
  bit prev_stall = 1'b0;
  logic [37:0] prev_bus;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic send(input int r, input logic [7:0] b);
    src_q[r].push_back(b);
  endtask

  task automatic apply_reset();
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b1;
    in_reset = 1'b1;
    exp_q.delete();
    e = '{addr: A_DIV, data: 32'(CLK_DIV_INIT), gid: -1, exp_reads: -1, exp_lat: -1, acc_cyc: 0};
    exp_q.push_back(e);
    e.addr = A_CTRL; e.data = 32'd0;
    exp_q.push_back(e);
    model_ptr = 0; model_first_tx = 1'b1; gap_on = 1'b0; exp_wr_next = 1'b0;
    seen_idle = 1'b0; ctrl_seen = 1'b0; prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_read", avm_m0_read == 1'b0, avm_m0_read, 0);
    chk("rst_write", avm_m0_write == 1'b0, avm_m0_write, 0);
    chk("rst_address", avm_m0_address == 3'd0, avm_m0_address, 0);
    chk("rst_writedata", avm_m0_writedata == 32'd0, avm_m0_writedata, 0);
    chk("rst_req_ready", req_ready == '0, req_ready, 0);
    chk("rst_busy", busy == 1'b1, busy, 1);
    chk("rst_grant_id", grant_id == 2'd0, grant_id, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    bit done = 1'b0;
    while (n < budget && !done) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && (req_valid == '0) && !busy;
      for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) done = 1'b0;
    end
    chk(name, done, n, budget);
  endtask

  // Requesters: each presents the head of its queue and holds it until accepted.
  initial begin
    req_valid = '0;
    cur_byte  = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pop_req[i]) begin
          pop_req[i] = 1'b0;
          void'(src_q[i].pop_front());
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && src_q[i].size() != 0 && $urandom_range(0, 99) < valid_pct) begin
          req_valid[i] = 1'b1;
          cur_byte[i]  = src_q[i][0];
        end
      end
    end
  end

  // UART slave: waitrequest policy and status word with a controllable trdy bit.
  initial begin
    int stall_cnt = 0;
    logic w;
    logic [31:0] r;
    avm_m0_waitrequest = 1'b0;
    avm_m0_readdata    = '0;
    forever begin
      @(posedge clk); #1;
      w = 1'b0;
      case (wait_mode)
        1: w = ($urandom_range(0, 99) < 30);
        2: if (avm_m0_write && avm_m0_address == A_TX && stall_cnt < 5) begin
             w = 1'b1;
             stall_cnt++;
           end
        3: w = avm_m0_read;
        default: w = 1'b0;
      endcase
      if (!avm_m0_write) stall_cnt = 0;
      r = $urandom;
      if (trdy_zeros > 0) r[1] = 1'b0;
      else if (trdy_rand) r[1] = ($urandom_range(0, 99) < 60);
      else r[1] = 1'b1;
      if (avm_m0_read && !w && trdy_zeros > 0) trdy_zeros--;
      avm_m0_waitrequest = w;
      avm_m0_readdata    = r;
    end
  end

  // Monitor and scoreboard.
  initial begin
    exp_t e;
    int g;
    logic [NUM_REQ-1:0] oh;
    logic [37:0] bus;
    forever begin
      @(negedge clk);
      cyc++;
      bus = {avm_m0_read, avm_m0_write, avm_m0_address, avm_m0_writedata, 1'b0};
      if (in_reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("hold_stable", bus == prev_bus, bus, prev_bus);
        if (avm_m0_read || avm_m0_write)
          chk("rd_wr_excl", !(avm_m0_read && avm_m0_write), {avm_m0_read, avm_m0_write}, 0);
        if (exp_wr_next) begin
          chk("poll_to_write", avm_m0_write && avm_m0_address == A_TX, {avm_m0_write, avm_m0_address}, {1'b1, A_TX});
          exp_wr_next = 1'b0;
        end
        if (gap_on) begin
          if (avm_m0_read) begin
            chk("poll_gap", gap_cnt == POLL_GAP, gap_cnt, POLL_GAP);
            gap_on = 1'b0;
          end else if (avm_m0_write) begin
            chk("write_in_gap", 1'b0, avm_m0_address, 0);
            gap_on = 1'b0;
          end else gap_cnt++;
        end
        if (!busy && !seen_idle) begin
          seen_idle = 1'b1;
          chk("init_to_idle", ctrl_seen && (cyc - ctrl_cyc) <= 3, cyc - ctrl_cyc, 3);
        end
        if (!busy && req_valid != '0) begin
          g = -1;
          for (int k = 0; k < NUM_REQ; k++)
            if (g < 0 && req_valid[(model_ptr + k) % NUM_REQ]) g = (model_ptr + k) % NUM_REQ;
          oh = '0;
          oh[g] = 1'b1;
          chk("grant", req_ready == oh, req_ready, oh);
          e.addr = A_TX;
          e.data = {24'b0, cur_byte[g]};
          e.gid = g;
          e.exp_reads = model_first_tx ? 0 : exp_polls;
          e.exp_lat = -1;
          if (clean && (model_first_tx || exp_polls >= 0))
            e.exp_lat = model_first_tx ? 1 : 2 + (exp_polls - 1) * (POLL_GAP + 1);
          e.acc_cyc = cyc;
          exp_q.push_back(e);
          pop_req[g] = 1'b1;
          model_ptr = (g + 1) % NUM_REQ;
          reads_cnt = 0;
        end else if (req_ready != '0) begin
          chk("spurious_ready", 1'b0, req_ready, 0);
        end
        if (avm_m0_read && !avm_m0_waitrequest) begin
          reads_cnt++;
          chk("read_stat", avm_m0_address == A_STAT && !model_first_tx, {model_first_tx, avm_m0_address}, A_STAT);
          if (avm_m0_readdata[1]) exp_wr_next = 1'b1;
          else begin
            gap_on = 1'b1;
            gap_cnt = 0;
          end
        end
        if (avm_m0_write && !avm_m0_waitrequest) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1'b0, {avm_m0_address, avm_m0_writedata}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", avm_m0_address == e.addr, avm_m0_address, e.addr);
            chk("wr_data", avm_m0_writedata == e.data, avm_m0_writedata, e.data);
            if (e.gid >= 0) chk("grant_id", int'(grant_id) == e.gid, grant_id, e.gid);
            if (e.exp_reads >= 0) chk("poll_count", reads_cnt == e.exp_reads, reads_cnt, e.exp_reads);
            if (e.exp_lat >= 0) chk("latency", (cyc - e.acc_cyc) == e.exp_lat, cyc - e.acc_cyc, e.exp_lat);
            if (e.addr == A_CTRL) begin
              ctrl_seen = 1'b1;
              ctrl_cyc = cyc;
            end
            if (e.addr == A_TX) model_first_tx = 1'b0;
            $display("write addr=%0d data=%08h grant_id=%0d cycle=%0d",
                     avm_m0_address, avm_m0_writedata, grant_id, cyc);
          end
        end
        prev_stall = (avm_m0_read || avm_m0_write) && avm_m0_waitrequest;
        prev_bus = bus;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    apply_reset();
    drain("init_done", 50);

    send(0, 8'h41);
    drain("first_byte", 200);

    trdy_zeros = 3;
    exp_polls = 4;
    send(0, 8'h42);
    drain("slow_trdy", 300);

    exp_polls = 1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NUM_REQ; i++) send(i, 8'(8'h10 + 16 * k + i));
    drain("all_valid", 500);

    wait_mode = 2;
    clean = 1'b0;
    send(2, 8'h5a);
    drain("write_stall", 200);

    wait_mode = 1;
    trdy_rand = 1'b1;
    exp_polls = -1;
    valid_pct = 40;
    for (int k = 0; k < 48; k++) send(int'($urandom_range(0, NUM_REQ - 1)), 8'($urandom));
    drain("random_mix", 6000);

    trdy_rand = 1'b0;
    valid_pct = 100;
    wait_mode = 3;
    send(1, 8'hc3);
    n = 0;
    while (n < 100 && !avm_m0_read) begin
      @(negedge clk);
      n++;
    end
    chk("reach_poll", avm_m0_read, avm_m0_read, 1);
    apply_reset();
    wait_mode = 0;
    clean = 1'b1;
    exp_polls = 1;
    send(3, 8'h77);
    send(0, 8'h78);
    drain("after_reset", 500);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
